sqrt_feeder: RTL

Operand-feeding stage placed directly upstream of the integer square-root core. Buffers 8-bit operands in a small FIFO and issues them one at a time to the core with a start pulse. Tracks the core's busy handshake, captures each root and presents it with its operand on a valid/ready result port. Flags stalled transactions with a timeout.

---
 rtl/sqrt_feeder_pkg.sv | 16 +
 rtl/sqrt_feeder_fifo.sv | 67 ++++++
 rtl/sqrt_feeder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sqrt_feeder_pkg.sv
// Shared types and defaults for the square-root operand feeder.
package sqrt_feeder_pkg;

  localparam int OP_W            = 8;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    OUT
  } feeder_state_t;

endpackage

// File: rtl/sqrt_feeder_fifo.sv
// Synchronous operand FIFO; en_i freezes every register, including the storage.
module sqrt_feeder_fifo
  import sqrt_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = OP_W
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   en_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop frees the slot, so a push alongside it is taken even when full.
  assign do_pop  = en_i & pop_i & ~empty_o;
  assign do_push = en_i & push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sqrt_feeder.sv
// Feeds buffered operands one at a time to the integer sqrt core and returns roots.
// Optional result self-check enabled by defining SQRT_FEEDER_CHECK_EN.
module sqrt_feeder
  import sqrt_feeder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   enb_i,
  input  logic                   in_valid_i,
  input  logic [OP_W-1:0]        in_data_i,
  output logic                   in_ready_o,
  output logic                   sq_start_o,
  output logic [OP_W-1:0]        sq_dt_o,
  input  logic                   sq_busy_i,
  input  logic [OP_W-1:0]        sq_res_i,
  output logic                   res_valid_o,
  output logic [OP_W-1:0]        res_data_o,
  output logic [OP_W-1:0]        res_op_o,
  input  logic                   res_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   timeout_o,
  output logic                   err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  feeder_state_t   state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [OP_W-1:0] res_data_q, res_data_d;
  logic [OP_W-1:0] res_op_q, res_op_d;
  logic            start_q, start_d;
  logic            res_valid_q, res_valid_d;
  logic            timeout_q, timeout_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic            timer_expired;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [OP_W-1:0] fifo_head;

  assign in_ready_o    = enb_i & ~fifo_full;
  assign fifo_push     = in_valid_i & in_ready_o;
  assign fifo_pop      = (state_q == ISSUE);
  assign timer_inc     = timer_q + TW'(1);
  assign timer_expired = (timer_inc == TW'(TIMEOUT));

  sqrt_feeder_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OP_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .en_i    (enb_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (in_data_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  // The operand is latched on entry to ISSUE so it is valid alongside the start pulse.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    start_d     = start_q;
    res_valid_d = res_valid_q;
    timeout_d   = timeout_q;
    timer_d     = timer_q;
    if (enb_i) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_d = ISSUE;
            start_d = 1'b1;
            op_d    = fifo_head;
          end
        end
        ISSUE: begin
          start_d = 1'b0;
          timer_d = '0;
          state_d = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (sq_busy_i) begin
            state_d = WAIT_DONE;
            timer_d = '0;
          end else if (timer_expired) begin
            timeout_d = 1'b1;
            timer_d   = '0;
            state_d   = IDLE;
          end else begin
            timer_d = timer_inc;
          end
        end
        WAIT_DONE: begin
          if (!sq_busy_i) begin
            res_data_d  = sq_res_i;
            res_op_d    = op_q;
            res_valid_d = 1'b1;
            state_d     = OUT;
          end else if (timer_expired) begin
            timeout_d = 1'b1;
            timer_d   = '0;
            state_d   = IDLE;
          end else begin
            timer_d = timer_inc;
          end
        end
        OUT: begin
          if (res_ready_i) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      op_q        <= '0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
    end
  end

  assign sq_start_o  = start_q;
  assign sq_dt_o     = op_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_op_o    = res_op_q;
  assign timeout_o   = timeout_q;

`ifdef SQRT_FEEDER_CHECK_EN
  logic        err_q, err_d;
  logic [16:0] root_sq, root_next_sq, operand_ext;
  logic        root_bad;

  // 17 bits holds (255+1)^2, so the upper bound never overflows.
  always_comb begin
    operand_ext  = 17'(op_q);
    root_sq      = 17'(sq_res_i) * 17'(sq_res_i);
    root_next_sq = (17'(sq_res_i) + 17'd1) * (17'(sq_res_i) + 17'd1);
    root_bad     = !((root_sq <= operand_ext) && (operand_ext < root_next_sq));
    err_d        = err_q;
    if (enb_i && (state_q == WAIT_DONE) && !sq_busy_i && root_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
